// File: rtl/rect_fill_scheduler.sv
// Pixel-write sequencer for the 160x120 frame: arbitrates screen-clear vs box-fill
// requests and walks the granted rectangle in raster order, one plot per cycle.
module rect_fill_scheduler #(
    parameter int XMAX = 159,
    parameter int YMAX = 119,
    parameter int XW   = 8,
    parameter int YW   = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_ack,
    input  logic          box_req,
    input  logic [XW-1:0] box_x0,
    input  logic [YW-1:0] box_y0,
    input  logic [XW-1:0] box_x1,
    input  logic [YW-1:0] box_y1,
    input  logic [2:0]    box_color,
    output logic          box_ack,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    color,
    output logic          plot,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;
    typedef enum logic {GR_CLR, GR_BOX} grant_t;

    localparam logic [XW-1:0] XMAX_C = XW'(XMAX);
    localparam logic [YW-1:0] YMAX_C = YW'(YMAX);

    state_t          state, state_nxt;
    grant_t          grant, last_grant;
    logic [XW-1:0]   xs, xe;
    logic [YW-1:0]   ye;

    logic            tie, pick_box;
    logic [XW-1:0]   x1c;
    logic [YW-1:0]   y1c;
    logic            box_empty;
    logic            last_pix;

    // On a tie the requester that did not win the previous tie goes first.
    assign tie      = clr_req & box_req;
    assign pick_box = box_req & (~clr_req | (last_grant == GR_CLR));

    assign x1c       = (box_x1 > XMAX_C) ? XMAX_C : box_x1;
    assign y1c       = (box_y1 > YMAX_C) ? YMAX_C : box_y1;
    assign box_empty = (box_x0 > x1c) || (box_y0 > y1c) ||
                       (box_x0 > XMAX_C) || (box_y0 > YMAX_C);

    assign last_pix = (x == xe) && (y == ye);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (clr_req || box_req) state_nxt = LOAD;
            LOAD: state_nxt = (grant == GR_BOX && box_empty) ? DONE : FILL;
            FILL: if (last_pix) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= GR_CLR;
            last_grant <= GR_BOX;
            xs         <= '0;
            xe         <= '0;
            ye         <= '0;
            x          <= '0;
            y          <= '0;
            color      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (clr_req || box_req)
                        grant <= pick_box ? GR_BOX : GR_CLR;
                    if (tie)
                        last_grant <= pick_box ? GR_BOX : GR_CLR;
                end
                LOAD: begin
                    if (grant == GR_CLR) begin
                        xs    <= '0;
                        xe    <= XMAX_C;
                        ye    <= YMAX_C;
                        x     <= '0;
                        y     <= '0;
                        color <= '0;
                    end else if (!box_empty) begin
                        // Empty boxes leave x/y untouched so they never leave the frame.
                        xs    <= box_x0;
                        xe    <= x1c;
                        ye    <= y1c;
                        x     <= box_x0;
                        y     <= box_y0;
                        color <= box_color;
                    end
                end
                FILL: begin
                    if (x != xe) begin
                        x <= x + 1'b1;
                    end else if (y != ye) begin
                        x <= xs;
                        y <= y + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign plot    = (state == FILL);
    assign busy    = (state != IDLE);
    assign clr_ack = (state == DONE) && (grant == GR_CLR);
    assign box_ack = (state == DONE) && (grant == GR_BOX);

endmodule

// File: tb/tb_rect_fill_scheduler.sv
// Scoreboard bench for rect_fill_scheduler: expected pixels are queued as jobs are
// requested and popped by a monitor on every plot; ack timing is checked per job.
module tb_rect_fill_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr_req = 1'b0;
    logic       box_req = 1'b0;
    logic [7:0] box_x0 = '0, box_x1 = '0;
    logic [6:0] box_y0 = '0, box_y1 = '0;
    logic [2:0] box_color = '0;
    logic       clr_ack, box_ack, plot, busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;

    int checks = 0, failures = 0, plot_cnt = 0, ack_cnt = 0;
    logic [31:0] q[$];

    rect_fill_scheduler dut (
        .clk(clk), .reset(reset),
        .clr_req(clr_req), .clr_ack(clr_ack),
        .box_req(box_req), .box_x0(box_x0), .box_y0(box_y0),
        .box_x1(box_x1), .box_y1(box_y1), .box_color(box_color), .box_ack(box_ack),
        .x(x), .y(y), .color(color), .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (clr_ack || box_ack) ack_cnt++;
        if (reset && plot) begin
            e = (q.size() > 0) ? q.pop_front() : 32'hffff_ffff;
            chk("pixel", {14'd0, x, y, color}, e);
            plot_cnt++;
        end
    end

    task automatic push_box(input int x0, input int y0, input int x1, input int y1,
                            input int c, output int n);
        if (x1 > 159) x1 = 159;
        if (y1 > 119) y1 = 119;
        n = 0;
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++) begin
                q.push_back({14'd0, 8'(xx), 7'(yy), 3'(c)});
                n++;
            end
    endtask

    task automatic drive_box(input int x0, input int y0, input int x1, input int y1,
                             input int c);
        box_x0 = 8'(x0); box_y0 = 7'(y0);
        box_x1 = 8'(x1); box_y1 = 7'(y1);
        box_color = 3'(c);
    endtask

    // Counts rising edges until an ack is seen, releases that requester, then
    // checks the ack was a single-cycle pulse and the block returned to idle.
    task automatic wait_ack(input bit want_clr, input int budget, output int edges);
        bit got;
        got = 1'b0;
        edges = 0;
        while (!got && edges < budget) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (clr_ack || box_ack) got = 1'b1;
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (got) begin
            chk("ack_who", {30'd0, clr_ack, box_ack}, want_clr ? 32'd2 : 32'd1);
            if (want_clr) clr_req = 1'b0; else box_req = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("ack_pulse", {29'd0, clr_ack, box_ack, busy}, 32'd0);
        end else begin
            clr_req = 1'b0;
            box_req = 1'b0;
        end
    endtask

    initial begin
        int n, nb, nc, e, base, a0;

        repeat (2) @(negedge clk);
        chk("rst_out", {10'd0, plot, busy, clr_ack, box_ack, x, y, color}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Clear only, one-cycle request.
        push_box(0, 0, 159, 119, 0, n);
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        chk("load_state", {30'd0, plot, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("first_plot", {31'd0, plot}, 32'd1);
        wait_ack(1'b1, 19300, e);
        chk("clr_latency", e, n);
        chk("clr_drain", q.size(), 0);

        // Small box.
        drive_box(10, 20, 12, 21, 5);
        push_box(10, 20, 12, 21, 5, n);
        box_req = 1'b1;
        wait_ack(1'b0, 100, e);
        chk("box_latency", e, n + 2);
        chk("box_drain", q.size(), 0);

        // Degenerate box: x0 > x1.
        base = plot_cnt;
        drive_box(50, 10, 40, 12, 3);
        box_req = 1'b1;
        wait_ack(1'b0, 100, e);
        chk("degen_latency", e, 2);
        chk("degen_plots", plot_cnt - base, 0);

        // Clamped box.
        drive_box(150, 115, 200, 127, 6);
        push_box(150, 115, 200, 127, 6, n);
        box_req = 1'b1;
        wait_ack(1'b0, 200, e);
        chk("clamp_latency", e, n + 2);
        chk("clamp_drain", q.size(), 0);

        // First tie: clear wins.
        drive_box(5, 5, 6, 6, 2);
        push_box(0, 0, 159, 119, 0, nc);
        push_box(5, 5, 6, 6, 2, nb);
        clr_req = 1'b1;
        box_req = 1'b1;
        wait_ack(1'b1, 19300, e);
        chk("tie1_clr_lat", e, nc + 2);
        wait_ack(1'b0, 100, e);
        chk("tie1_box_lat", e, nb + 2);
        chk("tie1_drain", q.size(), 0);

        // Second tie: box wins.
        drive_box(0, 0, 3, 2, 3);
        push_box(0, 0, 3, 2, 3, nb);
        push_box(0, 0, 159, 119, 0, nc);
        clr_req = 1'b1;
        box_req = 1'b1;
        wait_ack(1'b0, 100, e);
        chk("tie2_box_lat", e, nb + 2);
        wait_ack(1'b1, 19300, e);
        chk("tie2_clr_lat", e, nc + 2);
        chk("tie2_drain", q.size(), 0);

        // Reset in the middle of a clear.
        push_box(0, 0, 159, 119, 0, nc);
        base = plot_cnt;
        clr_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (plot_cnt - base >= 100) break;
        end
        chk("mid_reached", 32'(plot_cnt - base >= 100), 32'd1);
        #1;
        reset = 1'b0;
        clr_req = 1'b0;
        #1;
        chk("rst_async", {10'd0, plot, busy, clr_ack, box_ack, x, y, color}, 32'd0);
        q.delete();
        a0 = ack_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_ack", ack_cnt - a0, 0);
        chk("rst_idle", {30'd0, plot, busy}, 32'd0);

        drive_box(20, 30, 22, 30, 6);
        push_box(20, 30, 22, 30, 6, n);
        box_req = 1'b1;
        wait_ack(1'b0, 100, e);
        chk("post_rst_lat", e, n + 2);
        chk("post_rst_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rect_fill_scheduler.md
Name: rect_fill_scheduler

Overview:
- Sequences the VGA pixel-write datapath on the 160x120, 3-bit-colour frame.
- Shares the datapath between two requesters:
  - screen-clear: full frame, colour 000;
  - box-fill: filled rectangle, caller-supplied colour.
- Generates raster-order x/y and a plot strobe for the adapter's write port.
- Arbitrates simultaneous requests round-robin.

Parameters:
- XMAX, 159, last valid x coordinate.
- YMAX, 119, last valid y coordinate.
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr_req  in  1  level request: clear the whole screen.
- clr_ack  out  1  one-cycle pulse when the clear job completes.
- box_req  in  1  level request: fill a rectangle.
- box_x0  in  XW  rectangle left x.
- box_y0  in  YW  rectangle top y.
- box_x1  in  XW  rectangle right x.
- box_y1  in  YW  rectangle bottom y.
- box_color  in  3  rectangle fill colour.
- box_ack  out  1  one-cycle pulse when the box job completes.
- x  out  XW  pixel x.
- y  out  YW  pixel y.
- color  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE; last_grant=BOX, so clear wins the first tie.
  - x=0, y=0, color=000, plot=0, busy=0, clr_ack=0, box_ack=0.
  - Applies mid-job: the job is abandoned, no ack is issued, and there is no resume after release.
- States: IDLE, LOAD, FILL, DONE.
- IDLE: sample requests each cycle.
  - Only one request high: grant it.
  - Both high: grant the one not equal to last_grant, then update last_grant.
  - Neither high: stay in IDLE.
  - On grant: go to LOAD.
- LOAD (1 cycle), clear grant:
  - xs=0, xe=XMAX, ys=0, ye=YMAX, colour 000.
- LOAD (1 cycle), box grant:
  - Latch box_* inputs.
  - Clamp x1 to XMAX if x1>XMAX; clamp y1 to YMAX if y1>YMAX.
  - Set x=xs, y=ys.
  - If x0>x1 or y0>y1 after clamping, or x0>XMAX, or y0>YMAX: empty job, go to DONE with zero plots.
  - Otherwise go to FILL.
- Inputs that change after LOAD are ignored until the next grant.
- FILL: plot=1 every cycle; x, y and color are valid in the same cycle as plot.
  - x<xe: x<=x+1.
  - x==xe, y<ye: x<=xs, y<=y+1.
  - x==xe, y==ye: last pixel; go to DONE.
- Plot count per job:
  - box: (xe-xs+1)*(ye-ys+1);
  - clear: 19200.
- DONE (1 cycle):
  - plot=0.
  - Pulse the ack of the granted requester only.
  - Go to IDLE.
- Outputs while plot=0: x, y and color hold their last values.
- Timing:
  - Grant edge in IDLE to first plot: 2 cycles.
  - Ack is asserted 1 cycle after the last plot.
- Request protocol:
  - A requester must deassert req in the cycle its ack is high.
  - A req still high in IDLE after its ack is treated as a new job.
  - Under round-robin the other pending requester wins first.
- Coordinate arithmetic: unsigned; x and y never exceed XMAX/YMAX and never wrap.

Test Plan:
- Clear only: reset release, clr_req=1 for 1 cycle.
  - First plot 2 cycles after grant, at (0,0), color 000.
  - Exactly 19200 consecutive plots, last at (159,119).
  - clr_ack pulses the next cycle; busy=0 one cycle later.
- Box: (10,20)-(12,21), colour 101.
  - 6 plots in order (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), all color 101.
  - box_ack pulses once; clr_ack stays 0.
- Tie: clr_req and box_req rise in the same cycle, both held until their own ack.
  - Clear job runs first, then the box job.
  - On the next tie after reset-free operation, box wins.
- Degenerate box: x0=50, x1=40.
  - Zero plots.
  - box_ack 2 cycles after grant (LOAD, then DONE).
- Clamp: box (150,115)-(200,127).
  - 10x5 = 50 plots; max x=159, max y=119.
- Reset mid-FILL: assert reset=0 after 100 plots of a clear.
  - All outputs 0 immediately and asynchronously.
  - No ack issued.
  - A new box_req after release is served normally.
